hamming_controlador: RTL and testbench

Sequencer for the Hamming SEC/DED (7,4)+overall-parity datapath: Codificador, then error injection, then Decodificador/Correccion_de_error.
- Accepts 4-bit words plus an 8-bit error-injection mask from a requester over a valid/ready handshake.
- Drives the encoder, applies the mask, waits the datapath latency, and captures the corrected data and error flags.
- Returns the result over a second valid/ready handshake and keeps saturating statistics counters.
- Sits between the board-level stimulus logic (switches/UART) and the existing Hamming datapath.

---
 rtl/hamming_pkg.sv | 22 ++
 rtl/contador_saturante.sv | 25 ++
 rtl/hamming_controlador.sv | 242 ++++++++++++++++++++++++
 tb/tb_hamming_controlador.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared types and constants for the Hamming SEC/DED sequencer.
package hamming_pkg;

    typedef enum logic [2:0] {
        LIBRE     = 3'd0,
        CODIFICAR = 3'd1,
        INYECTAR  = 3'd2,
        ESPERA    = 3'd3,
        ENTREGAR  = 3'd4
    } estado_t;

    localparam int LAT_COD_DEF = 1;
    localparam int LAT_DEC_DEF = 2;
    localparam int PALABRA_W   = 8;
    localparam int DATO_W      = 4;

    // Returns {doble, simple}; an uncorrectable error suppresses the single-error flag.
    function automatic logic [1:0] resolver_banderas(input logic simple, input logic doble);
        return {doble, simple & ~doble};
    endfunction

endpackage

// File: rtl/contador_saturante.sv
// Statistics counter that sticks at all-ones; clear has priority over increment.
module contador_saturante #(
    parameter int W = 16
) (
    input  logic         reloj,
    input  logic         reset,
    input  logic         inc,
    input  logic         borrar,
    output logic [W-1:0] valor
);

    // Counter register with saturation at the top value.
    always_ff @(posedge reloj) begin
        if (reset) begin
            valor <= '0;
        end else if (borrar) begin
            valor <= '0;
        end else if (inc && (valor != {W{1'b1}})) begin
            valor <= valor + W'(1);
        end else begin
            valor <= valor;
        end
    end

endmodule

// File: rtl/hamming_controlador.sv
// Sequencer around the Hamming encoder / error injection / decoder datapath.
// Optional macro HAMMING_REINTENTO_EN re-runs a word without its mask after a double error.
module hamming_controlador
    import hamming_pkg::*;
#(
    parameter int LAT_COD        = LAT_COD_DEF,
    parameter int LAT_DEC        = LAT_DEC_DEF,
    parameter int CNT_W          = 16,
    parameter int MAX_REINTENTOS = 1
) (
    input  logic                 reloj,
    input  logic                 reset,
    input  logic                 dato_valido,
    output logic                 dato_listo,
    input  logic [DATO_W-1:0]    dato,
    input  logic [PALABRA_W-1:0] mascara,
    output logic [DATO_W-1:0]    cod_dato,
    input  logic [PALABRA_W-1:0] cod_palabra,
    output logic [PALABRA_W-1:0] dec_recibido,
    input  logic [DATO_W-1:0]    cor_corregido,
    input  logic                 cor_error_simple,
    input  logic                 cor_error_doble,
    output logic                 sal_valido,
    input  logic                 sal_listo,
    output logic [DATO_W-1:0]    sal_dato,
    output logic                 sal_simple,
    output logic                 sal_doble,
    output logic                 sal_reintentado,
    input  logic                 borrar_contadores,
    output logic [CNT_W-1:0]     cnt_palabras,
    output logic [CNT_W-1:0]     cnt_simples,
    output logic [CNT_W-1:0]     cnt_dobles,
    output logic [CNT_W-1:0]     cnt_reintentos
);

    localparam int LAT_MAX = (LAT_COD > LAT_DEC) ? LAT_COD : LAT_DEC;
    localparam int ESP_W   = (LAT_MAX < 2) ? 1 : $clog2(LAT_MAX);

    if ((LAT_COD < 1) || (LAT_DEC < 1) || (MAX_REINTENTOS < 0)) begin : g_param_invalido
        $error("hamming_controlador: LAT_COD and LAT_DEC must be >= 1, MAX_REINTENTOS >= 0");
    end

    estado_t              r_estado, w_estado_sig;
    logic [ESP_W-1:0]     r_espera, w_espera_sig;
    logic [PALABRA_W-1:0] r_mascara, w_mascara_sig;
    logic [PALABRA_W-1:0] r_palabra, w_palabra_sig;
    logic [PALABRA_W-1:0] r_dec_recibido, w_dec_sig;
    logic [DATO_W-1:0]    r_cod_dato, w_cod_sig;
    logic [DATO_W-1:0]    r_sal_dato, w_sal_dato_sig;
    logic                 r_dato_listo, w_dato_listo_sig;
    logic                 r_sal_valido, w_sal_valido_sig;
    logic                 r_sal_simple, w_sal_simple_sig;
    logic                 r_sal_doble, w_sal_doble_sig;
    logic [1:0]           w_banderas;
    logic                 w_acepta;
    logic                 w_entrega;
    logic                 w_fin_espera;
    logic                 w_reintentar;
    logic                 w_reintento;

    assign w_acepta     = (r_estado == LIBRE) && dato_valido && r_dato_listo;
    assign w_entrega    = (r_estado == ENTREGAR) && r_sal_valido && sal_listo;
    assign w_fin_espera = (r_estado == ESPERA) && (r_espera == '0);
    assign w_banderas   = resolver_banderas(cor_error_simple, cor_error_doble);
    assign w_reintento  = w_fin_espera && w_reintentar;

`ifdef HAMMING_REINTENTO_EN
    localparam int REI_W = (MAX_REINTENTOS < 1) ? 1 : $clog2(MAX_REINTENTOS + 1);

    logic [REI_W-1:0] r_reintentos;
    logic             r_sal_reintentado;

    assign w_reintentar = cor_error_doble && (r_reintentos < REI_W'(MAX_REINTENTOS));

    // Per-word retry budget and the "came from a retry" result flag.
    always_ff @(posedge reloj) begin
        if (reset) begin
            r_reintentos      <= '0;
            r_sal_reintentado <= 1'b0;
        end else begin
            if (w_acepta) begin
                r_reintentos <= '0;
            end else if (w_reintento) begin
                r_reintentos <= r_reintentos + REI_W'(1);
            end else begin
                r_reintentos <= r_reintentos;
            end
            if (w_fin_espera && !w_reintentar) begin
                r_sal_reintentado <= (r_reintentos != '0);
            end else begin
                r_sal_reintentado <= r_sal_reintentado;
            end
        end
    end

    assign sal_reintentado = r_sal_reintentado;
`else
    assign w_reintentar    = 1'b0;
    assign sal_reintentado = 1'b0;
`endif

    // Next-state and next-register values for the sequencer.
    always_comb begin
        w_estado_sig     = r_estado;
        w_espera_sig     = r_espera;
        w_mascara_sig    = r_mascara;
        w_palabra_sig    = r_palabra;
        w_dec_sig        = r_dec_recibido;
        w_cod_sig        = r_cod_dato;
        w_sal_dato_sig   = r_sal_dato;
        w_dato_listo_sig = r_dato_listo;
        w_sal_valido_sig = r_sal_valido;
        w_sal_simple_sig = r_sal_simple;
        w_sal_doble_sig  = r_sal_doble;
        case (r_estado)
            LIBRE: begin
                if (w_acepta) begin
                    w_cod_sig        = dato;
                    w_mascara_sig    = mascara;
                    w_espera_sig     = ESP_W'(LAT_COD - 1);
                    w_dato_listo_sig = 1'b0;
                    w_estado_sig     = CODIFICAR;
                end else begin
                    w_dato_listo_sig = 1'b1;
                end
            end
            CODIFICAR: begin
                if (r_espera == '0) begin
                    w_palabra_sig = cod_palabra;
                    w_estado_sig  = INYECTAR;
                end else begin
                    w_espera_sig = r_espera - ESP_W'(1);
                end
            end
            INYECTAR: begin
                w_dec_sig    = r_palabra ^ r_mascara;
                w_espera_sig = ESP_W'(LAT_DEC - 1);
                w_estado_sig = ESPERA;
            end
            ESPERA: begin
                if (r_espera != '0) begin
                    w_espera_sig = r_espera - ESP_W'(1);
                end else if (w_reintentar) begin
                    // Second pass without injected errors, encoder input still held.
                    w_mascara_sig = '0;
                    w_espera_sig  = ESP_W'(LAT_COD - 1);
                    w_estado_sig  = CODIFICAR;
                end else begin
                    w_sal_dato_sig   = cor_corregido;
                    w_sal_doble_sig  = w_banderas[1];
                    w_sal_simple_sig = w_banderas[0];
                    w_sal_valido_sig = 1'b1;
                    w_estado_sig     = ENTREGAR;
                end
            end
            ENTREGAR: begin
                if (w_entrega) begin
                    w_sal_valido_sig = 1'b0;
                    w_dato_listo_sig = 1'b1;
                    w_estado_sig     = LIBRE;
                end else begin
                    w_sal_valido_sig = 1'b1;
                end
            end
            default: begin
                w_sal_valido_sig = 1'b0;
                w_dato_listo_sig = 1'b1;
                w_estado_sig     = LIBRE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge reloj) begin
        if (reset) begin
            r_estado       <= LIBRE;
            r_espera       <= '0;
            r_mascara      <= '0;
            r_palabra      <= '0;
            r_dec_recibido <= '0;
            r_cod_dato     <= '0;
            r_sal_dato     <= '0;
            r_dato_listo   <= 1'b1;
            r_sal_valido   <= 1'b0;
            r_sal_simple   <= 1'b0;
            r_sal_doble    <= 1'b0;
        end else begin
            r_estado       <= w_estado_sig;
            r_espera       <= w_espera_sig;
            r_mascara      <= w_mascara_sig;
            r_palabra      <= w_palabra_sig;
            r_dec_recibido <= w_dec_sig;
            r_cod_dato     <= w_cod_sig;
            r_sal_dato     <= w_sal_dato_sig;
            r_dato_listo   <= w_dato_listo_sig;
            r_sal_valido   <= w_sal_valido_sig;
            r_sal_simple   <= w_sal_simple_sig;
            r_sal_doble    <= w_sal_doble_sig;
        end
    end

    assign dato_listo   = r_dato_listo;
    assign cod_dato     = r_cod_dato;
    assign dec_recibido = r_dec_recibido;
    assign sal_valido   = r_sal_valido;
    assign sal_dato     = r_sal_dato;
    assign sal_simple   = r_sal_simple;
    assign sal_doble    = r_sal_doble;

    contador_saturante #(.W(CNT_W)) u_cnt_palabras (
        .reloj  (reloj),
        .reset  (reset),
        .inc    (w_entrega),
        .borrar (borrar_contadores),
        .valor  (cnt_palabras)
    );

    contador_saturante #(.W(CNT_W)) u_cnt_simples (
        .reloj  (reloj),
        .reset  (reset),
        .inc    (w_entrega && r_sal_simple),
        .borrar (borrar_contadores),
        .valor  (cnt_simples)
    );

    contador_saturante #(.W(CNT_W)) u_cnt_dobles (
        .reloj  (reloj),
        .reset  (reset),
        .inc    (w_entrega && r_sal_doble),
        .borrar (borrar_contadores),
        .valor  (cnt_dobles)
    );

    contador_saturante #(.W(CNT_W)) u_cnt_reintentos (
        .reloj  (reloj),
        .reset  (reset),
        .inc    (w_reintento),
        .borrar (borrar_contadores),
        .valor  (cnt_reintentos)
    );

endmodule

// File: tb/tb_hamming_controlador.sv
// Self-checking bench: behavioural Hamming datapath plus a result scoreboard.
module tb_hamming_controlador;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [3:0] d;
        logic       s;
        logic       db;
        logic       r;
    } res_t;

    logic             reloj = 1'b0;
    logic             reset;
    logic             dato_valido;
    logic             dato_listo;
    logic [3:0]       dato;
    logic [7:0]       mascara;
    logic [3:0]       cod_dato;
    logic [7:0]       cod_palabra;
    logic [7:0]       dec_recibido;
    logic [3:0]       cor_corregido;
    logic             cor_error_simple;
    logic             cor_error_doble;
    logic             sal_valido;
    logic             sal_listo;
    logic [3:0]       sal_dato;
    logic             sal_simple;
    logic             sal_doble;
    logic             sal_reintentado;
    logic             borrar_contadores;
    logic [CNT_W-1:0] cnt_palabras;
    logic [CNT_W-1:0] cnt_simples;
    logic [CNT_W-1:0] cnt_dobles;
    logic [CNT_W-1:0] cnt_reintentos;
    logic             ambos = 1'b0;

    int   n_cmp = 0;
    int   n_err = 0;
    int   m_pal = 0;
    int   m_sim = 0;
    int   m_dob = 0;
    int   m_rei = 0;
    res_t cola[$];

    always #5 reloj = ~reloj;

    hamming_controlador #(
        .LAT_COD(1), .LAT_DEC(2), .CNT_W(CNT_W), .MAX_REINTENTOS(1)
    ) dut (
        .reloj(reloj), .reset(reset),
        .dato_valido(dato_valido), .dato_listo(dato_listo),
        .dato(dato), .mascara(mascara),
        .cod_dato(cod_dato), .cod_palabra(cod_palabra),
        .dec_recibido(dec_recibido), .cor_corregido(cor_corregido),
        .cor_error_simple(cor_error_simple), .cor_error_doble(cor_error_doble),
        .sal_valido(sal_valido), .sal_listo(sal_listo),
        .sal_dato(sal_dato), .sal_simple(sal_simple), .sal_doble(sal_doble),
        .sal_reintentado(sal_reintentado), .borrar_contadores(borrar_contadores),
        .cnt_palabras(cnt_palabras), .cnt_simples(cnt_simples),
        .cnt_dobles(cnt_dobles), .cnt_reintentos(cnt_reintentos)
    );

    // Hamming(7,4) positions 1..7 in bits 0..6, overall parity in bit 7.
    function automatic logic [7:0] codificar(input logic [3:0] d);
        logic [7:0] p;
        p[2] = d[0]; p[4] = d[1]; p[5] = d[2]; p[6] = d[3];
        p[0] = d[0] ^ d[1] ^ d[3];
        p[1] = d[0] ^ d[2] ^ d[3];
        p[3] = d[1] ^ d[2] ^ d[3];
        p[7] = ^p[6:0];
        return p;
    endfunction

    function automatic logic [5:0] decodificar(input logic [7:0] r);
        logic [2:0] s;
        logic [7:0] c;
        logic       sim;
        logic       dob;
        s   = {r[3] ^ r[4] ^ r[5] ^ r[6], r[1] ^ r[2] ^ r[5] ^ r[6], r[0] ^ r[2] ^ r[4] ^ r[6]};
        c   = r;
        sim = 1'b0;
        dob = 1'b0;
        if (^r) begin
            sim = 1'b1;
            if (s != 3'd0) c[s - 3'd1] = ~c[s - 3'd1];
        end else if (s != 3'd0) begin
            dob = 1'b1;
        end
        return {c[6], c[5], c[4], c[2], sim, dob};
    endfunction

    assign cod_palabra = codificar(cod_dato);

    always_ff @(posedge reloj) begin
        if (ambos) {cor_corregido, cor_error_simple, cor_error_doble} <= {decodificar(dec_recibido) >> 2, 2'b11};
        else       {cor_corregido, cor_error_simple, cor_error_doble} <= decodificar(dec_recibido);
    end

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic enviar(input logic [3:0] d, input logic [7:0] m);
        int t;
        @(negedge reloj);
        dato = d; mascara = m; dato_valido = 1'b1;
        t = 0;
        while (dato_listo !== 1'b1 && t < 50) begin
            @(negedge reloj);
            t++;
        end
        n_cmp++;
        if (dato_listo !== 1'b1) begin
            n_err++;
            $display("FAIL enviar_timeout dato_listo=%b required 1", dato_listo);
        end
        @(posedge reloj);
        @(negedge reloj);
        dato_valido = 1'b0; dato = 4'($urandom); mascara = 8'($urandom);
    endtask

    task automatic esperar_salida(output res_t obs, output int lat);
        lat = 0;
        while (sal_valido !== 1'b1 && lat < 40) begin
            @(negedge reloj);
            lat++;
        end
        n_cmp++;
        if (sal_valido !== 1'b1) begin
            n_err++;
            $display("FAIL salida_timeout sal_valido=%b required 1", sal_valido);
        end
        obs = {sal_dato, sal_simple, sal_doble, sal_reintentado};
    endtask

    task automatic modelo_contar(input res_t e, input logic borrar);
        if (borrar) begin
            m_pal = 0; m_sim = 0; m_dob = 0; m_rei = 0;
        end else begin
            m_pal = sat(m_pal);
            if (e.s)  m_sim = sat(m_sim);
            if (e.db) m_dob = sat(m_dob);
            if (e.r)  m_rei = sat(m_rei);
        end
    endtask

    task automatic transaccion(input logic [3:0] d, input logic [7:0] m, input logic borrar,
                               input res_t esp, output res_t obs, output res_t req, output int lat);
        cola.push_back(esp);
        enviar(d, m);
        esperar_salida(obs, lat);
        borrar_contadores = borrar;
        @(posedge reloj);
        @(negedge reloj);
        borrar_contadores = 1'b0;
        req = cola.pop_front();
        modelo_contar(req, borrar);
    endtask

    task automatic test_reset();
        reset = 1'b1; dato_valido = 1'b0; dato = 4'd0; mascara = 8'd0;
        sal_listo = 1'b1; borrar_contadores = 1'b0;
        repeat (3) @(negedge reloj);
        n_cmp++;
        if ({dato_listo, sal_valido, sal_dato, sal_simple, sal_doble, sal_reintentado} !== 9'b1_0_0000_000) begin
            n_err++;
            $display("FAIL reset_ctrl got=%b%b%h%b%b%b required 1 0 0 000", dato_listo, sal_valido,
                     sal_dato, sal_simple, sal_doble, sal_reintentado);
        end
        n_cmp++;
        if ({cod_dato, dec_recibido, cnt_palabras, cnt_simples, cnt_dobles, cnt_reintentos} !== 28'd0) begin
            n_err++;
            $display("FAIL reset_datos cod=%h dec=%h cnt=%h %h %h %h required 0", cod_dato, dec_recibido,
                     cnt_palabras, cnt_simples, cnt_dobles, cnt_reintentos);
        end
        reset = 1'b0;
    endtask

    task automatic test_basico();
        res_t obs, req;
        int   lat;
        transaccion(4'b1010, 8'h00, 1'b0, {4'b1010, 1'b0, 1'b0, 1'b0}, obs, req, lat);
        n_cmp++;
        if (obs !== req) begin n_err++; $display("FAIL limpio got=%h required %h", obs, req); end
        n_cmp++;
        if (lat !== 4) begin n_err++; $display("FAIL latencia got=%0d required 4", lat); end
        n_cmp++;
        if (cnt_palabras !== 4'd1) begin n_err++; $display("FAIL cnt_palabras_1 got=%0d required 1", cnt_palabras); end
        transaccion(4'b0010, 8'h04, 1'b0, {4'b0010, 1'b1, 1'b0, 1'b0}, obs, req, lat);
        n_cmp++;
        if (obs !== req) begin n_err++; $display("FAIL simple got=%h required %h", obs, req); end
        n_cmp++;
        if (cnt_simples !== 4'd1) begin n_err++; $display("FAIL cnt_simples_1 got=%0d required 1", cnt_simples); end
    endtask

    task automatic test_doble();
        res_t obs, req, esp;
        int   lat, lat_req;
`ifdef HAMMING_REINTENTO_EN
        esp = {4'b1101, 1'b0, 1'b0, 1'b1}; lat_req = 8;
`else
        esp = {4'b1101, 1'b0, 1'b1, 1'b0}; lat_req = 4;
`endif
        transaccion(4'b1101, 8'h03, 1'b0, esp, obs, req, lat);
        n_cmp++;
        if (obs !== req) begin n_err++; $display("FAIL doble got=%h required %h", obs, req); end
        n_cmp++;
        if (lat !== lat_req) begin n_err++; $display("FAIL latencia_doble got=%0d required %0d", lat, lat_req); end
`ifdef HAMMING_REINTENTO_EN
        esp = {4'b0101, 1'b0, 1'b1, 1'b1};
`else
        esp = {4'b0101, 1'b0, 1'b1, 1'b0};
`endif
        ambos = 1'b1;
        transaccion(4'b0101, 8'h00, 1'b0, esp, obs, req, lat);
        ambos = 1'b0;
        n_cmp++;
        if (obs !== req) begin n_err++; $display("FAIL ambas_banderas got=%h required %h", obs, req); end
    endtask

    task automatic test_contadores();
        n_cmp++;
        if ({cnt_palabras, cnt_simples, cnt_dobles, cnt_reintentos} !==
            {4'(m_pal), 4'(m_sim), 4'(m_dob), 4'(m_rei)}) begin
            n_err++;
            $display("FAIL contadores got=%h %h %h %h required %0d %0d %0d %0d", cnt_palabras, cnt_simples,
                     cnt_dobles, cnt_reintentos, m_pal, m_sim, m_dob, m_rei);
        end
    endtask

    task automatic test_contrapresion();
        res_t obs, req;
        int   lat;
        int   malos;
        sal_listo = 1'b0;
        cola.push_back({4'b0110, 1'b0, 1'b0, 1'b0});
        enviar(4'b0110, 8'h00);
        esperar_salida(obs, lat);
        malos = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge reloj);
            if (sal_valido !== 1'b1 || sal_dato !== 4'b0110 || dato_listo !== 1'b0) malos++;
        end
        n_cmp++;
        if (malos != 0) begin
            n_err++;
            $display("FAIL contrapresion inestable_ciclos=%0d required 0 (valido=%b dato=%h listo=%b)",
                     malos, sal_valido, sal_dato, dato_listo);
        end
        sal_listo = 1'b1;
        @(posedge reloj);
        @(negedge reloj);
        req = cola.pop_front();
        modelo_contar(req, 1'b0);
        n_cmp++;
        if (obs !== req) begin n_err++; $display("FAIL contrapresion_dato got=%h required %h", obs, req); end
        n_cmp++;
        if ({sal_valido, dato_listo} !== 2'b01) begin
            n_err++;
            $display("FAIL liberar got valido=%b listo=%b required 0 1", sal_valido, dato_listo);
        end
    endtask

    task automatic test_saturacion();
        res_t       obs, req;
        int         lat;
        logic [3:0] d;
        logic [7:0] m;
        for (int i = 0; i < 20; i++) begin
            d = 4'($urandom);
            m = (i % 3 == 0) ? 8'h00 : (8'h01 << $urandom_range(7, 0));
            transaccion(d, m, 1'b0, {d, (m != 8'h00), 1'b0, 1'b0}, obs, req, lat);
            n_cmp++;
            if (obs !== req) begin n_err++; $display("FAIL sat_palabra_%0d got=%h required %h", i, obs, req); end
        end
        n_cmp++;
        if (cnt_palabras !== 4'hF) begin n_err++; $display("FAIL saturado got=%0d required 15", cnt_palabras); end
        test_contadores();
        transaccion(4'b0001, 8'h00, 1'b1, {4'b0001, 1'b0, 1'b0, 1'b0}, obs, req, lat);
        n_cmp++;
        if ({cnt_palabras, cnt_simples, cnt_dobles, cnt_reintentos} !== 16'd0) begin
            n_err++;
            $display("FAIL borrar got=%h %h %h %h required 0", cnt_palabras, cnt_simples, cnt_dobles, cnt_reintentos);
        end
    endtask

    task automatic test_reset_espera();
        res_t obs, req;
        int   lat;
        int   pulsos;
        transaccion(4'b1001, 8'h00, 1'b0, {4'b1001, 1'b0, 1'b0, 1'b0}, obs, req, lat);
        enviar(4'b0111, 8'h10);
        repeat (2) @(negedge reloj);
        reset = 1'b1;
        @(posedge reloj);
        @(negedge reloj);
        reset = 1'b0;
        n_cmp++;
        if ({dato_listo, sal_valido, sal_simple, sal_doble, sal_reintentado} !== 5'b10000 ||
            {cod_dato, dec_recibido, sal_dato} !== 16'd0) begin
            n_err++;
            $display("FAIL reset_espera listo=%b valido=%b cod=%h dec=%h sal=%h required 1 0 0 0 0",
                     dato_listo, sal_valido, cod_dato, dec_recibido, sal_dato);
        end
        n_cmp++;
        if ({cnt_palabras, cnt_simples, cnt_dobles, cnt_reintentos} !== 16'd0) begin
            n_err++;
            $display("FAIL reset_contadores got=%h %h %h %h required 0", cnt_palabras, cnt_simples,
                     cnt_dobles, cnt_reintentos);
        end
        m_pal = 0; m_sim = 0; m_dob = 0; m_rei = 0;
        pulsos = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge reloj);
            if (sal_valido === 1'b1) pulsos++;
        end
        n_cmp++;
        if (pulsos != 0) begin n_err++; $display("FAIL resultado_parcial pulsos=%0d required 0", pulsos); end
        transaccion(4'b0011, 8'h80, 1'b0, {4'b0011, 1'b1, 1'b0, 1'b0}, obs, req, lat);
        n_cmp++;
        if (obs !== req || lat !== 4) begin
            n_err++;
            $display("FAIL tras_reset got=%h lat=%0d required %h lat=4", obs, lat, req);
        end
    endtask

    initial begin
        test_reset();
        test_basico();
        test_doble();
        test_contadores();
        test_contrapresion();
        test_contadores();
        test_saturacion();
        test_reset_espera();
        test_contadores();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time_limit_reached required completion");
        $fatal(1, "bench time limit");
    end

endmodule
